decoder_stage_controller: RTL and testbench

- Central sequencer for the processing-unit array of one decoding window.
- Drives the shared global_stage bus through measurement loading, grow/merge iterations, peeling and result hand-off.
- Decides stage exits from registered OR-reductions of all PU busy and odd flags.
- Sits between the syndrome loader (start handshake) and the correction readout (result handshake).

---
 rtl/decoder_stage_controller.sv | 171 +++++++++++++++++
 tb/tb_decoder_stage_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_stage_controller.sv
// Stage sequencer for one decoding window: load, grow/merge iterations, peeling, result hand-off.
// Stage exits are decided from registered OR-reductions of the PU busy and odd flags.
module decoder_stage_controller #(
    parameter int unsigned PU_COUNT       = 64,
    parameter int unsigned STAGE_WIDTH    = 3,
    parameter int unsigned SETTLE_CYCLES  = 3,
    parameter int unsigned GROW_CYCLES    = 2,
    parameter int unsigned MAX_ITER       = 31,
    parameter int unsigned ITER_WIDTH     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CYC_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [PU_COUNT-1:0]    pu_busy,
    input  logic [PU_COUNT-1:0]    pu_odd,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   decode_error,
    output logic [ITER_WIDTH-1:0]  iter_count,
    output logic [CYC_WIDTH-1:0]   cycle_count
);

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = STAGE_WIDTH'(0);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = STAGE_WIDTH'(1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = STAGE_WIDTH'(2);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = STAGE_WIDTH'(3);
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = STAGE_WIDTH'(4);
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = STAGE_WIDTH'(5);

    typedef enum logic [STAGE_WIDTH-1:0] {
        StIdle   = STAGE_IDLE,
        StLoad   = STAGE_MEASUREMENT_LOADING,
        StGrow   = STAGE_GROW,
        StMerge  = STAGE_MERGE,
        StPeel   = STAGE_PEELING,
        StResult = STAGE_RESULT_VALID
    } state_e;

    localparam int unsigned SettleW = 4;
    localparam int unsigned GrowW   = (GROW_CYCLES > 1) ? $clog2(GROW_CYCLES) : 1;
    localparam int unsigned TimeW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [SettleW-1:0]    SettleDone = SettleW'(SETTLE_CYCLES);
    localparam logic [GrowW-1:0]      GrowLast   = GrowW'(GROW_CYCLES - 1);
    localparam logic [TimeW-1:0]      TimeLast   = TimeW'(TIMEOUT_CYCLES - 1);
    localparam logic [ITER_WIDTH-1:0] IterMax    = ITER_WIDTH'(MAX_ITER);

    state_e                state_q, state_d;
    logic                  any_busy_q, any_odd_q;
    logic [SettleW-1:0]    settle_q, settle_d;
    logic [TimeW-1:0]      visit_q, visit_d;
    logic [GrowW-1:0]      grow_q, grow_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic [CYC_WIDTH-1:0]  cyc_q, cyc_d;
    logic                  err_q, err_d;
    logic                  settled;
    logic                  working;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            any_busy_q <= 1'b0;
            any_odd_q  <= 1'b0;
            settle_q   <= '0;
            visit_q    <= '0;
            grow_q     <= '0;
            iter_q     <= '0;
            cyc_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            any_busy_q <= |pu_busy;
            any_odd_q  <= |pu_odd;
            settle_q   <= settle_d;
            visit_q    <= visit_d;
            grow_q     <= grow_d;
            iter_q     <= iter_d;
            cyc_q      <= cyc_d;
            err_q      <= err_d;
        end
    end

    // Busy is only trusted once the PU stage/busy registers and our reduction have caught up.
    assign settled = (settle_q == SettleDone);
    assign working = state_q inside {StLoad, StGrow, StMerge, StPeel};

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        visit_d  = visit_q;
        grow_d   = grow_q;
        iter_d   = iter_q;
        cyc_d    = cyc_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (start_valid) begin
                    state_d = StLoad;
                    iter_d  = '0;
                    cyc_d   = CYC_WIDTH'(1);
                    err_d   = 1'b0;
                end
            end
            StLoad: state_d = StGrow;
            StGrow: begin
                if (grow_q == GrowLast) begin
                    state_d = StMerge;
                end else begin
                    grow_d = grow_q + GrowW'(1);
                end
            end
            StMerge, StPeel: begin
                visit_d = visit_q + TimeW'(1);
                if (!settled) begin
                    settle_d = settle_q + SettleW'(1);
                end
                if (visit_q == TimeLast) begin
                    err_d   = 1'b1;
                    state_d = StResult;
                end else if (settled && !any_busy_q) begin
                    if (state_q == StPeel) begin
                        state_d = StResult;
                    end else if (!any_odd_q) begin
                        state_d = StPeel;
                    end else if (iter_q < IterMax) begin
                        state_d = StGrow;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StResult;
                    end
                end
            end
            StResult: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Per-visit counters restart on every stage change; iterations are counted on GROW entry.
        if (state_d != state_q) begin
            settle_d = '0;
            visit_d  = '0;
            grow_d   = '0;
            if (state_d == StGrow) begin
                iter_d = iter_q + ITER_WIDTH'(1);
            end
        end

        if (working && state_d != StResult && cyc_q != '1) begin
            cyc_d = cyc_q + CYC_WIDTH'(1);
        end
    end

    assign global_stage = state_q;
    assign start_ready  = (state_q == StIdle);
    assign result_valid = (state_q == StResult);
    assign decode_error = err_q;
    assign iter_count   = iter_q;
    assign cycle_count  = cyc_q;

    stage_legal_a: assert property (@(posedge clk) disable iff (reset)
        state_q inside {StIdle, StLoad, StGrow, StMerge, StPeel, StResult});

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Directed bench for decoder_stage_controller: per-cycle comparison against a behavioural model
// plus hand-computed literal expectations for each scenario.
module tb_decoder_stage_controller;

    localparam int PU    = 64;
    localparam int SETL  = 3;
    localparam int GROWC = 2;
    localparam int MAXIT = 31;
    localparam int TOUT  = 20;

    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_GROW  = 2;
    localparam int S_MERGE = 3;
    localparam int S_PEEL  = 4;
    localparam int S_RV    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic [PU-1:0] pu_busy;
    logic [PU-1:0] pu_odd;
    logic [2:0]    global_stage;
    logic          result_valid;
    logic          result_ready;
    logic          decode_error;
    logic [4:0]    iter_count;
    logic [15:0]   cycle_count;

    decoder_stage_controller #(
        .PU_COUNT      (PU),
        .STAGE_WIDTH   (3),
        .SETTLE_CYCLES (SETL),
        .GROW_CYCLES   (GROWC),
        .MAX_ITER      (MAXIT),
        .ITER_WIDTH    (5),
        .TIMEOUT_CYCLES(TOUT),
        .CYC_WIDTH     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .pu_busy      (pu_busy),
        .pu_odd       (pu_odd),
        .global_stage (global_stage),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .decode_error (decode_error),
        .iter_count   (iter_count),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stage plus cycles spent in it, and round bookkeeping by timestamps.
    int m_stage = S_IDLE;
    int m_dwell = 0;
    int m_iter  = 0;
    int m_cyc   = 0;
    int m_err   = 0;
    bit m_busy_r = 1'b0;
    bit m_odd_r  = 1'b0;
    int tick_n   = 0;
    int m_load_at = 0;

    always @(posedge clk) begin : model
        int ns;
        int t;
        tick_n <= tick_n + 1;
        if (reset) begin
            m_stage  <= S_IDLE;
            m_dwell  <= 0;
            m_iter   <= 0;
            m_cyc    <= 0;
            m_err    <= 0;
            m_busy_r <= 1'b0;
            m_odd_r  <= 1'b0;
        end else begin
            m_busy_r <= (pu_busy != '0);
            m_odd_r  <= (pu_odd != '0);
            ns = m_stage;
            case (m_stage)
                S_IDLE: if (start_valid) begin
                    ns = S_LOAD;
                    m_iter    <= 0;
                    m_err     <= 0;
                    m_load_at <= tick_n;
                end
                S_LOAD: ns = S_GROW;
                S_GROW: if (m_dwell + 1 >= GROWC) ns = S_MERGE;
                S_MERGE, S_PEEL: begin
                    if (m_dwell + 1 == TOUT) begin
                        ns = S_RV;
                        m_err <= 1;
                    end else if (m_dwell >= SETL && !m_busy_r) begin
                        if (m_stage == S_PEEL) ns = S_RV;
                        else if (!m_odd_r) ns = S_PEEL;
                        else if (m_iter < MAXIT) ns = S_GROW;
                        else begin
                            ns = S_RV;
                            m_err <= 1;
                        end
                    end
                end
                S_RV: if (result_ready) ns = S_IDLE;
                default: ns = S_IDLE;
            endcase
            m_dwell <= (ns == m_stage) ? m_dwell + 1 : 0;
            if (ns == S_GROW && m_stage != S_GROW) m_iter <= m_iter + 1;
            if (ns == S_RV && m_stage != S_RV) begin
                t = tick_n - m_load_at;
                m_cyc <= (t > 65535) ? 65535 : t;
            end
            m_stage <= ns;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("m_stage", int'(global_stage), m_stage);
            check("m_start_ready", int'(start_ready), int'(m_stage == S_IDLE));
            check("m_result_valid", int'(result_valid), int'(m_stage == S_RV));
            check("m_iter_count", int'(iter_count), m_iter);
            check("m_decode_error", int'(decode_error), m_err);
            if (m_stage == S_IDLE || m_stage == S_RV)
                check("m_cycle_count", int'(cycle_count), m_cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("release_idle", int'(global_stage), S_IDLE);
    endtask

    int nominal_seq[12] = '{1, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 5};

    initial begin
        int merge1;
        int peel_cnt;
        int grows;
        int prev;
        int n;
        bit saw_peel;

        reset = 1'b1;
        start_valid = 1'b1;
        result_ready = 1'b0;
        pu_busy = '0;
        pu_odd = '0;
        tick();
        model_on = 1'b1;
        tick();
        check("rst_stage", int'(global_stage), S_IDLE);
        check("rst_start_ready", int'(start_ready), 1);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_iter", int'(iter_count), 0);
        check("rst_cycles", int'(cycle_count), 0);
        check("rst_error", int'(decode_error), 0);
        reset = 1'b0;
        start_valid = 1'b0;
        tick();
        check("idle_hold", int'(global_stage), S_IDLE);

        // No-error round
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("nominal_seq", int'(global_stage), nominal_seq[k]);
            if (k != 11) tick();
        end
        check("nominal_valid", int'(result_valid), 1);
        check("nominal_iter", int'(iter_count), 1);
        check("nominal_cycles", int'(cycle_count), 11);
        check("nominal_error", int'(decode_error), 0);
        release_result();

        // Two iterations
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        merge1 = 0;
        for (int k = 0; k <= 20; k++) begin
            pu_odd[5]  = (k >= 3 && k <= 8);
            pu_busy[0] = (k >= 5 && k <= 7);
            if (k < 10 && global_stage == 3'(S_MERGE)) merge1++;
            if (k == 10) check("iter2_regrow", int'(global_stage), S_GROW);
            if (k == 16) check("iter2_peel", int'(global_stage), S_PEEL);
            if (k != 20) tick();
        end
        pu_odd = '0;
        pu_busy = '0;
        check("iter2_merge1_len", merge1, 7);
        check("iter2_valid", int'(result_valid), 1);
        check("iter2_iter", int'(iter_count), 2);
        check("iter2_cycles", int'(cycle_count), 20);
        check("iter2_error", int'(decode_error), 0);
        release_result();

        // Iteration abort
        pu_odd[0] = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        grows = 0;
        saw_peel = 1'b0;
        prev = S_LOAD;
        n = 0;
        while (!result_valid && n < 400) begin
            if (global_stage == 3'(S_GROW) && prev != S_GROW) grows++;
            if (global_stage == 3'(S_PEEL)) saw_peel = 1'b1;
            prev = int'(global_stage);
            tick();
            n++;
        end
        check("abort_reached", int'(result_valid), 1);
        check("abort_error", int'(decode_error), 1);
        check("abort_iter", int'(iter_count), 31);
        check("abort_grows", grows, 31);
        check("abort_no_peel", int'(saw_peel), 0);
        check("abort_cycles", int'(cycle_count), 187);
        pu_odd = '0;
        release_result();

        // Timeout in PEELING
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        peel_cnt = 0;
        for (int k = 0; k <= 27; k++) begin
            pu_busy[63] = (k >= 6);
            if (global_stage == 3'(S_PEEL)) peel_cnt++;
            if (k != 27) tick();
        end
        check("tout_peel_len", peel_cnt, 20);
        check("tout_valid", int'(result_valid), 1);
        check("tout_error", int'(decode_error), 1);
        check("tout_cycles", int'(cycle_count), 27);
        pu_busy = '0;
        release_result();

        // Handshake hold then simultaneous result_ready/start_valid
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        for (int i = 0; i < 10; i++) begin
            check("hs_valid", int'(result_valid), 1);
            check("hs_start_ready", int'(start_ready), 0);
            check("hs_iter", int'(iter_count), 1);
            check("hs_cycles", int'(cycle_count), 11);
            check("hs_error", int'(decode_error), 0);
            tick();
        end
        result_ready = 1'b1;
        start_valid = 1'b1;
        check("hs_still_valid", int'(result_valid), 1);
        tick();
        result_ready = 1'b0;
        check("hs_idle", int'(global_stage), S_IDLE);
        check("hs_idle_ready", int'(start_ready), 1);
        check("hs_idle_valid", int'(result_valid), 0);
        tick();
        start_valid = 1'b0;
        check("hs_accept", int'(global_stage), S_LOAD);

        // Reset mid-MERGE
        for (int k = 0; k < 4; k++) tick();
        check("mid_merge", int'(global_stage), S_MERGE);
        reset = 1'b1;
        start_valid = 1'b1;
        tick();
        check("mrst_stage", int'(global_stage), S_IDLE);
        check("mrst_ready", int'(start_ready), 1);
        check("mrst_iter", int'(iter_count), 0);
        check("mrst_valid", int'(result_valid), 0);
        reset = 1'b0;
        start_valid = 1'b0;
        tick();
        check("mrst_no_accept", int'(global_stage), S_IDLE);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
